// File: rtl/register_file.sv
//------------------------------------------------------------------------------
// register_file : 32 x 64-bit register file, two combinational read ports, one
//                 synchronous write port, X31 hard-wired to zero.
// Optional macro: REGFILE_BYPASS_EN (forward BusW onto a matching read port).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module register_file (
  input  logic        Clk,
  input  logic        ResetL,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  input  logic [4:0]  RW,
  input  logic [63:0] BusW,
  input  logic        RegWr,
  output logic [63:0] BusA,
  output logic [63:0] BusB
);

  localparam int        NUM_REGS = 31;
  localparam logic [4:0] XZR     = 5'd31;

  logic [63:0] regs_q [NUM_REGS];
  logic [63:0] regs_d [NUM_REGS];
  logic [63:0] rd_view [32];
  logic        wr_ok;

  assign wr_ok = RegWr && (RW != XZR);

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && (RW == 5'(i))) begin
        regs_d[i] = BusW;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Full 32-entry view so read addresses never index past the storage.
  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_view
      assign rd_view[g] = regs_q[g];
    end
  endgenerate
  assign rd_view[31] = '0;

  always_comb begin
    BusA = rd_view[RA];
    BusB = rd_view[RB];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (RW == RA)) BusA = BusW;
    if (wr_ok && (RW == RB)) BusB = BusW;
`endif
    if (!ResetL) begin
      BusA = '0;
      BusB = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
//------------------------------------------------------------------------------
// tb_register_file : directed + random self-checking bench for register_file.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_file;

  logic        Clk;
  logic        ResetL;
  logic [4:0]  RA, RB, RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic [63:0] BusA, BusB;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [32];

  register_file dut (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .RB(RB), .RW(RW),
    .BusW(BusW), .RegWr(RegWr), .BusA(BusA), .BusB(BusB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected read value from the architectural rules.
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (!ResetL) return 64'd0;
    if (a == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (RegWr && RW != 5'd31 && RW == a) return BusW;
`endif
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag);
    chk({tag, "_A"}, BusA, exp_rd(RA));
    chk({tag, "_B"}, BusB, exp_rd(RB));
  endtask

  // Drive inputs at the falling edge, clock once, update model, sample 4 ns later.
  task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                      input logic [63:0] w, input logic we);
    @(negedge Clk);
    RA = ra; RB = rb; RW = rw; BusW = w; RegWr = we;
    @(posedge Clk);
    if (ResetL && we && rw != 5'd31) model[rw] = w;
    #4;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    ResetL = 1'b0; RA = 5'd0; RB = 5'd1; RW = 5'd0; BusW = '0; RegWr = 1'b0;

    #12;
    chk_both("reset_initial");
    @(negedge Clk);
    ResetL = 1'b1;

    // Mid-run reset clears immediately, blocks writes.
    step(5'd5, 5'd5, 5'd5, 64'h1234, 1'b1);
    chk("x5_written", BusA, 64'h1234);
    @(negedge Clk);
    RegWr = 1'b0; RA = 5'd5;
    #1;
    ResetL = 1'b0;
    #3;
    chk("reset_async_A", BusA, 64'd0);
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    step(5'd6, 5'd6, 5'd6, rnd64(), 1'b1);
    chk_both("write_in_reset");
    @(negedge Clk);
    RegWr = 1'b0;
    ResetL = 1'b1;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #4;
      chk_both("post_reset_zero");
    end

    // Write/read sweep.
    for (int i = 0; i < 32; i++) begin
      step(5'(i), 5'(i), 5'(i), rnd64(), 1'b1);
      chk_both("sweep");
    end

    // Writes disabled: nothing may change.
    for (int i = 0; i < 32; i++) begin
      step(5'(i), 5'(i), 5'(i), rnd64(), 1'b0);
      chk_both("no_write");
    end

    // XZR write discarded.
    step(5'd31, 5'd31, 5'd31, 64'hDEADBEEF, 1'b1);
    chk("xzr_A", BusA, 64'd0);
    chk("xzr_B", BusB, 64'd0);
    @(negedge Clk);
    RegWr = 1'b0;
    for (int i = 0; i < 31; i++) begin
      RA = 5'(i); RB = 5'(i);
      #4;
      chk_both("xzr_others");
    end

    // Dual port.
    step(5'd0, 5'd0, 5'd3, 64'hAAAA_0000_0000_5555, 1'b1);
    step(5'd0, 5'd0, 5'd7, 64'h0123_4567_89AB_CDEF, 1'b1);
    @(negedge Clk);
    RegWr = 1'b0; RA = 5'd3; RB = 5'd7;
    #4;
    chk("dual_A", BusA, 64'hAAAA_0000_0000_5555);
    chk("dual_B", BusB, 64'h0123_4567_89AB_CDEF);

    // Same-cycle read of the address being written.
    @(negedge Clk);
    RW = 5'd10; RA = 5'd10; RB = 5'd31; BusW = 64'hCAFE; RegWr = 1'b1;
    #4;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_before", BusA, 64'hCAFE);
`else
    chk("rdw_before", BusA, model[10]);
`endif
    chk("rdw_before_xzr", BusB, 64'd0);
    @(posedge Clk);
    model[10] = 64'hCAFE;
    #4;
    chk("rdw_after", BusA, 64'hCAFE);

    // Randomized traffic, checked before and after each edge.
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      RA = 5'($urandom_range(0, 31));
      RB = 5'($urandom_range(0, 31));
      RW = ($urandom_range(0, 3) == 0) ? RA : 5'($urandom_range(0, 31));
      BusW = rnd64();
      RegWr = 1'($urandom_range(0, 1));
      #4;
      chk_both("rand_pre");
      @(posedge Clk);
      if (RegWr && RW != 5'd31) model[RW] = BusW;
      #4;
      chk_both("rand_post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
